mul_sched: RTL and testbench

Two-requester scheduler and sequencer for the shared 24×24 shift-add multiply / popcount datapath in the GPIO emulator. It arbitrates round-robin between two operand sources and runs the accepted operation bit-serially over 24 cycles. It then counts the ones in the low 32 product bits and returns the result with the requester ID over a valid/ready response channel. It also keeps a completed-operation counter for the GPIO output pins.

---
 rtl/mul_sched.sv | 183 ++++++++++++++++++
 tb/tb_mul_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sched.sv
// mul_sched: round-robin scheduler for two operand requesters feeding a bit-serial
// 24x24 shift-add multiplier, followed by a popcount of the low 32 product bits.
module mul_sched (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [23:0] req0_a,
  input  logic [23:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [23:0] req1_a,
  input  logic [23:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [47:0] rsp_product,
  output logic [5:0]  rsp_ones,
  output logic        rsp_ovf,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MULT  = 2'd1,
    S_COUNT = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [4:0] LAST_BIT = 5'd23;

  state_e      state_q, state_d;
  logic [23:0] a_q, a_d;
  logic [23:0] b_q, b_d;
  logic        id_q, id_d;
  logic [47:0] acc_q, acc_d;
  logic [4:0]  idx_q, idx_d;
  logic        prio_q, prio_d;
  logic [47:0] prod_q, prod_d;
  logic [5:0]  ones_q, ones_d;
  logic        ovf_q, ovf_d;
  logic        rid_q, rid_d;
  logic [15:0] op_count_q, op_count_d;

  logic grant;
  logic accept;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

  // Priority only matters on a tie; a lone valid requester always wins.
  assign grant  = (req0_valid && req1_valid) ? prio_q : req1_valid;
  // Readies are gated by reset so nothing is accepted while n_reset is low.
  assign accept = n_reset && (state_q == S_IDLE) && (req0_valid || req1_valid);

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples the pre-edge value of every other register.
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default for every combinational output up front means no path
    // leaves it unassigned, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_MULT;
      S_MULT:  if (idx_q == LAST_BIT) state_d = S_COUNT;
      S_COUNT: state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy       = 1'b0;
        req0_ready = accept && req0_valid && !grant;
        req1_ready = accept && req1_valid && grant;
      end
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: operand capture, shift-add, popcount and counter.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    prio_d     = prio_q;
    prod_d     = prod_q;
    ones_d     = ones_q;
    ovf_d      = ovf_q;
    rid_d      = rid_q;
    op_count_d = op_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d    = grant ? req1_a : req0_a;
          b_d    = grant ? req1_b : req0_b;
          id_d   = grant;
          acc_d  = '0;
          idx_d  = '0;
          prio_d = ~grant;
        end
      end
      S_MULT: begin
        if (b_q[idx_q]) begin
          acc_d = acc_q + (48'(a_q) << idx_q);
        end
        idx_d = idx_q + 5'd1;
      end
      S_COUNT: begin
        prod_d = acc_q;
        ones_d = popcount32(acc_q[31:0]);
        ovf_d  = |acc_q[47:32];
        rid_d  = id_q;
      end
      S_RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
        end
      end
    endcase
  end

  // Datapath registers; all are reset so a reset mid-operation leaves no trace.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      acc_q      <= '0;
      idx_q      <= '0;
      prio_q     <= 1'b0;
      prod_q     <= '0;
      ones_q     <= '0;
      ovf_q      <= 1'b0;
      rid_q      <= 1'b0;
      op_count_q <= '0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      prio_q     <= prio_d;
      prod_q     <= prod_d;
      ones_q     <= ones_d;
      ovf_q      <= ovf_d;
      rid_q      <= rid_d;
      op_count_q <= op_count_d;
    end
  end

  assign rsp_id      = rid_q;
  assign rsp_product = prod_q;
  assign rsp_ones    = ones_q;
  assign rsp_ovf     = ovf_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: randomized and directed stimulus for mul_sched, checked by a
// negedge monitor against a transaction-level model and response scoreboard.
module tb_mul_sched;

  localparam int unsigned CYCLE_LIMIT = 20000;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [23:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf, busy;
  logic [47:0] rsp_product;
  logic [5:0]  rsp_ones;
  logic [15:0] op_count;

  mul_sched dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_product(rsp_product),
    .rsp_ones   (rsp_ones),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        id;
    logic [47:0] product;
    logic [5:0]  ones;
    logic        ovf;
    int unsigned due;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_count = '0;
  logic        m_prio = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          tmo_cnt = 0;
  int          preload_req = 0;
  int          preload_seen = 0;
  bit          finish_req = 1'b0;
  int          rsp_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares the DUT against the model, then advances the model
  // through whatever handshakes the model says happen on the coming edge.
  always @(negedge clk) begin
    logic e_grant, e_r0, e_r1, e_valid;
    logic [23:0] ea, eb;
    exp_t e;
    if (preload_req != preload_seen) begin
      m_count = 16'hFFFF;
      preload_seen = preload_req;
    end
    if (!n_reset) begin
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_op_count", op_count, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_product", rsp_product, 0);
      check("rst_rsp_ones", rsp_ones, 0);
      check("rst_rsp_ovf", rsp_ovf, 0);
      exp_q.delete();
      m_count = '0;
      m_prio  = 1'b0;
    end else begin
      e_grant = (req0_valid && req1_valid) ? m_prio : req1_valid;
      e_r0    = (exp_q.size() == 0) && req0_valid && !e_grant;
      e_r1    = (exp_q.size() == 0) && req1_valid && e_grant;
      e_valid = (exp_q.size() != 0) && (cyc >= exp_q[0].due);
      check("req0_ready", req0_ready, e_r0);
      check("req1_ready", req1_ready, e_r1);
      check("busy", busy, exp_q.size() != 0);
      check("rsp_valid", rsp_valid, e_valid);
      check("op_count", op_count, m_count);
      if (e_valid) begin
        check("rsp_id", rsp_id, exp_q[0].id);
        check("rsp_product", rsp_product, exp_q[0].product);
        check("rsp_ones", rsp_ones, exp_q[0].ones);
        check("rsp_ovf", rsp_ovf, exp_q[0].ovf);
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          m_count = m_count + 16'd1;
        end
      end
      if (e_r0 || e_r1) begin
        ea        = e_grant ? req1_a : req0_a;
        eb        = e_grant ? req1_b : req0_b;
        e.id      = e_grant;
        e.product = 48'(ea) * 48'(eb);
        e.ones    = 6'($countones(e.product[31:0]));
        e.ovf     = (e.product[47:32] != 16'd0);
        e.due     = cyc + 26;
        exp_q.push_back(e);
        m_prio = ~e_grant;
      end
    end
    if (finish_req || cyc > CYCLE_LIMIT) begin
      check("watchdog_cycles_ok", cyc > CYCLE_LIMIT, 0);
      check("scoreboard_empty", exp_q.size(), 0);
      check("stimulus_timeouts", tmo_cnt, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  function automatic logic [23:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return 24'h0;
      1:       return 24'hFFFFFF;
      default: return r[23:0];
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    n_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;
  endtask

  task automatic wait_accept(input bit who);
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if ((who == 1'b0 && req0_ready) || (who == 1'b1 && req1_ready)) break;
    end
    if (n == 300) begin
      tmo_cnt++;
      $display("FAIL accept_timeout requester %0d: got no ready expected ready", who);
    end
    @(posedge clk); #1;
    if (who == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic issue(input bit who, input logic [23:0] a, input logic [23:0] b);
    @(posedge clk); #1;
    if (who == 1'b0) begin
      req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
    wait_accept(who);
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) break;
    end
    if (n == 1000) begin
      tmo_cnt++;
      $display("FAIL idle_timeout: got busy expected idle");
    end
  endtask

  initial begin
    logic a0, a1;
    int   n;
    n_reset    = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;

    // Single op and max operands.
    issue(1'b0, 24'd3, 24'd5);
    wait_idle();
    issue(1'b1, 24'hFFFFFF, 24'hFFFFFF);
    wait_idle();

    // Fairness: both requesters held valid from reset.
    do_reset();
    @(posedge clk); #1;
    req0_a = 24'd0; req0_b = 24'h123456; req1_a = 24'd2; req1_b = 24'd2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp_seen = 0;
    for (n = 0; n < 400 && rsp_seen < 4; n++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) rsp_seen++;
    end
    if (rsp_seen < 4) begin
      tmo_cnt++;
      $display("FAIL fairness_timeout: got %0d responses expected 4", rsp_seen);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Backpressure with the other requester waiting.
    rsp_ready = 1'b0;
    issue(1'b0, 24'hABCDEF, 24'h00F00F);
    req1_a = 24'h000101; req1_b = 24'h0000FF; req1_valid = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    if (n == 100) begin
      tmo_cnt++;
      $display("FAIL backpressure_timeout: got no rsp_valid expected rsp_valid");
    end
    repeat (10) @(negedge clk);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_accept(1'b1);
    wait_idle();

    // Reset in the middle of MULT, then a clean op.
    issue(1'b0, 24'h00FFFF, 24'h0F0F0F);
    repeat (9) @(posedge clk);
    #1 n_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;
    issue(1'b0, 24'd3, 24'd5);
    wait_idle();

    // Random traffic with random backpressure and occasional withdrawal.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      a0 = req0_ready;
      a1 = req1_ready;
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (a0 || (req0_valid && $urandom_range(0, 19) == 0)) req0_valid = 1'b0;
      else if (!req0_valid && $urandom_range(0, 7) == 0) begin
        req0_a = rand_op(); req0_b = rand_op(); req0_valid = 1'b1;
      end
      if (a1 || (req1_valid && $urandom_range(0, 19) == 0)) req1_valid = 1'b0;
      else if (!req1_valid && $urandom_range(0, 7) == 0) begin
        req1_a = rand_op(); req1_b = rand_op(); req1_valid = 1'b1;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle();

    // Counter wrap: preload 0xFFFF while idle, then complete one op.
    @(posedge clk); #1;
    force dut.op_count_q = 16'hFFFF;
    preload_req++;
    repeat (2) @(posedge clk);
    #1 release dut.op_count_q;
    issue(1'b1, 24'd7, 24'd9);
    wait_idle();
    repeat (2) @(negedge clk);
    finish_req = 1'b1;
  end

endmodule
